// File: rtl/spoc_pkg.sv
// rtl/spoc_pkg.sv - shared types and constants for the permutation scheduler
package spoc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DOM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_STEPS       = 18;
  localparam int DEF_ROUNDS_PER_STEP = 6;

  localparam logic [5:0] RC_SEED = 6'h3F;

endpackage

// File: rtl/perm_rc_lfsr.sv
// rtl/perm_rc_lfsr.sv - round-constant LFSR, seeded on init and stepped on adv
module perm_rc_lfsr
  import spoc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       adv,
  output logic [5:0] rc
);

  // Load the seed at the start of a call, otherwise shift once per advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= 6'd0;
    end else if (init) begin
      rc <= RC_SEED;
    end else if (adv) begin
      rc <= {rc[4:0], rc[5] ^ rc[4]};
    end
  end

endmodule

// File: rtl/perm_sched.sv
// rtl/perm_sched.sv - permutation round scheduler; SPOC_PERM_ABORT_EN adds an abort input
module perm_sched
  import spoc_pkg::*;
#(
  parameter int NUM_STEPS       = DEF_NUM_STEPS,
  parameter int ROUNDS_PER_STEP = DEF_ROUNDS_PER_STEP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef SPOC_PERM_ABORT_EN
  input  logic       abort,
`endif
  input  logic [1:0] ctrl_word,
  output logic       busy,
  output logic       done,
  output logic       en_state,
  output logic       en_dom,
  output logic [1:0] dom_word,
  output logic [5:0] rc,
  output logic       step_last,
  output logic [4:0] step_cnt
);

  localparam int RW = (ROUNDS_PER_STEP > 1) ? $clog2(ROUNDS_PER_STEP) : 1;
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS_PER_STEP - 1);
  localparam logic [SW-1:0] STEP_FINAL = SW'(NUM_STEPS - 1);

  state_t        state;
  logic [RW-1:0] round_q;
  logic [SW-1:0] step_q;
  logic          kill;
  logic          accept;
  logic          round_wrap;
  logic          run_end;
  logic [5:0]    lfsr_rc;

`ifdef SPOC_PERM_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign accept     = start && (state == S_IDLE || state == S_DONE);
  assign round_wrap = (round_q == ROUND_LAST);
  assign run_end    = round_wrap && (step_q == STEP_FINAL);

  perm_rc_lfsr u_rc (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .adv  ((state == S_RUN) && !kill),
    .rc   (lfsr_rc)
  );

  // Round-dependent outputs only carry information while the datapath runs
  assign rc        = en_state ? lfsr_rc : 6'd0;
  assign step_last = en_state && round_wrap;
  assign step_cnt  = en_state ? 5'(step_q) : 5'd0;

  // Sequence IDLE -> DOM -> RUN -> DONE and register the control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      en_state <= 1'b0;
      en_dom   <= 1'b0;
      dom_word <= 2'd0;
      round_q  <= '0;
      step_q   <= '0;
    end else begin
      done   <= 1'b0;
      en_dom <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_DOM;
            dom_word <= ctrl_word;
            busy     <= 1'b1;
            en_dom   <= 1'b1;
            round_q  <= '0;
            step_q   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DOM: begin
          if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= S_RUN;
            en_state <= 1'b1;
          end
        end
        S_RUN: begin
          if (kill || run_end) begin
            // abort wins over completion when both land on the final round
            state    <= kill ? S_IDLE : S_DONE;
            done     <= !kill;
            busy     <= 1'b0;
            en_state <= 1'b0;
            round_q  <= '0;
            step_q   <= '0;
          end else if (round_wrap) begin
            round_q <= '0;
            step_q  <= step_q + SW'(1);
          end else begin
            round_q <= round_q + RW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_sched.sv
// tb/tb_perm_sched.sv - scoreboard bench for perm_sched
module tb_perm_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] ctrl_word = 2'd0;
`ifdef SPOC_PERM_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic       en_state;
  logic       en_dom;
  logic [1:0] dom_word;
  logic [5:0] rc;
  logic       step_last;
  logic [4:0] step_cnt;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic [1:0] word;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [5:0] rc;
    logic       sl;
    logic [4:0] sc;
  } run_t;

  ev_t  exp_dom[$];
  ev_t  exp_done[$];
  run_t exp_run[$];
  ev_t  dev;
  run_t rev;

  perm_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SPOC_PERM_ABORT_EN
    .abort     (abort),
`endif
    .ctrl_word (ctrl_word),
    .busy      (busy),
    .done      (done),
    .en_state  (en_state),
    .en_dom    (en_dom),
    .dom_word  (dom_word),
    .rc        (rc),
    .step_last (step_last),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag, input logic [1:0] word);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_en_state"}, 32'(en_state), 0);
    chk({tag, "_en_dom"}, 32'(en_dom), 0);
    chk({tag, "_step_last"}, 32'(step_last), 0);
    chk({tag, "_rc"}, 32'(rc), 0);
    chk({tag, "_step_cnt"}, 32'(step_cnt), 0);
    chk({tag, "_dom_word"}, 32'(dom_word), 32'(word));
  endtask

  // Expected events of one call whose start is accepted at cycle c0
  task automatic expect_call(input int c0, input logic [1:0] w, input int n_run, input bit with_done);
    logic [5:0] r;
    r = 6'h3F;
    exp_dom.push_back('{c0 + 1, w});
    for (int k = 0; k < n_run; k++) begin
      exp_run.push_back('{c0 + 2 + k, r, (k % 6) == 5, 5'(k / 6)});
      r = {r[4:0], r[5] ^ r[4]};
    end
    if (with_done) exp_done.push_back('{c0 + 110, w});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic go(input logic [1:0] w, input int n_run, input bit with_done, output int c0);
    c0 = cyc;
    expect_call(c0, w, n_run, with_done);
    start     = 1'b1;
    ctrl_word = w;
    tick();
    start = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT presents an event
  always @(negedge clk) begin
    if (en_dom) begin
      if (exp_dom.size() == 0) begin
        chk("en_dom_unexpected", 32'(en_dom), 0);
      end else begin
        dev = exp_dom.pop_front();
        chk("en_dom_cycle", cyc, dev.cyc);
        chk("dom_word", 32'(dom_word), 32'(dev.word));
        chk("busy_in_dom", 32'(busy), 1);
      end
    end
    if (en_state) begin
      if (exp_run.size() == 0) begin
        chk("en_state_unexpected", 32'(en_state), 0);
      end else begin
        rev = exp_run.pop_front();
        chk("run_cycle", cyc, rev.cyc);
        chk("rc", 32'(rc), 32'(rev.rc));
        chk("step_last", 32'(step_last), 32'(rev.sl));
        chk("step_cnt", 32'(step_cnt), 32'(rev.sc));
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        chk("done_unexpected", 32'(done), 0);
      end else begin
        dev = exp_done.pop_front();
        chk("done_cycle", cyc, dev.cyc);
        chk("done_dom_word", 32'(dom_word), 32'(dev.word));
        chk("busy_in_done", 32'(busy), 0);
      end
    end
  end

  initial begin
    int c0;
    int c1;

    rst = 1'b1;
    repeat (3) tick();
    check_idle("reset", 2'b00);
    rst = 1'b0;
    tick();
    tick();

    // single call; a start pulse at RUN cycle 40 must be ignored
    go(2'b10, 108, 1'b1, c0);
    wait_to(c0 + 42);
    start     = 1'b1;
    ctrl_word = 2'b11;
    tick();
    start = 1'b0;
    wait_to(c0 + 115);
    check_idle("after_single", 2'b10);

    // back-to-back: start held through DONE with a new ctrl_word
    go(2'b10, 108, 1'b1, c1);
    expect_call(c1 + 110, 2'b01, 108, 1'b1);
    wait_to(c1 + 100);
    start     = 1'b1;
    ctrl_word = 2'b01;
    wait_to(c1 + 111);
    start = 1'b0;
    wait_to(c1 + 225);
    check_idle("after_b2b", 2'b01);

    // reset at RUN cycle 50 clears everything immediately
    go(2'b11, 108, 1'b1, c0);
    wait_to(c0 + 52);
    #2;
    rst = 1'b1;
    #1;
    check_idle("rst_mid_run", 2'b00);
    exp_dom.delete();
    exp_run.delete();
    exp_done.delete();
    tick();
    rst = 1'b0;
    tick();
    go(2'b01, 108, 1'b1, c0);
    wait_to(c0 + 115);
    check_idle("after_rst_call", 2'b01);

`ifdef SPOC_PERM_ABORT_EN
    // abort on the final RUN cycle beats completion
    go(2'b10, 108, 1'b0, c0);
    wait_to(c0 + 109);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_last", 2'b10);
    wait_to(c0 + 116);
    check_idle("after_abort", 2'b10);
`endif

    chk("dom_queue_left", exp_dom.size(), 0);
    chk("run_queue_left", exp_run.size(), 0);
    chk("done_queue_left", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perm_sched.md
PERM_SCHED -- requirements
Module: perm_sched

Interface
REQ-001 Parameter NUM_STEPS, default 18, permutation steps per call.
REQ-002 Parameter ROUNDS_PER_STEP, default 6, rounds per step.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port start, input, 1, permutation request, sampled only in IDLE or DONE.
REQ-006 Port ctrl_word, input, 2, domain-separation code, latched on accepted start.
REQ-007 Port busy, output, 1, high in DOM and RUN.
REQ-008 Port done, output, 1, one-cycle completion pulse.
REQ-009 Port en_state, output, 1, datapath state-register enable, high every RUN cycle.
REQ-010 Port en_dom, output, 1, high in DOM only; datapath XORs dom_word into state.
REQ-011 Port dom_word, output, 2, latched ctrl_word.
REQ-012 Port rc, output, 6, round constant for the current RUN cycle.
REQ-013 Port step_last, output, 1, high on the last round of each step.
REQ-014 Port step_cnt, output, 5, current step index, 0..NUM_STEPS-1.

Function
REQ-015 FSM states IDLE, DOM, RUN, DONE; encoding is an implementation choice.
REQ-016 IDLE: start=1 -> DOM; otherwise stay in IDLE.
REQ-017 DOM lasts exactly one cycle, then RUN; round_cnt, step_cnt and rc are initialised on entry.
REQ-018 RUN lasts exactly NUM_STEPS*ROUNDS_PER_STEP cycles, then DONE.
REQ-019 Round counter counts 0..ROUNDS_PER_STEP-1 and wraps to 0 after its final value.
REQ-020 step_cnt increments when the round counter wraps.
REQ-021 DONE lasts one cycle: start=1 -> DOM (back-to-back, new ctrl_word latched); otherwise -> IDLE.
REQ-022 start is ignored in DOM and RUN; it is not queued.
REQ-023 rc comes from an LFSR seeded to 6'h3F on DOM entry; each RUN cycle the next value is {rc[4:0], rc[5]^rc[4]}.
REQ-024 rc, step_cnt and step_last are 0 outside RUN.
REQ-025 Latency with defaults: start accepted at cycle 0 -> en_dom at cycle 1, en_state at cycles 2..109, done at cycle 110.
REQ-026 Counter widths are sized from the parameters; step_cnt is zero-extended to 5 bits.

Reset
REQ-027 rst asserted forces IDLE, and sets busy, done, en_state, en_dom, step_last to 0; dom_word, rc, step_cnt and counters to 0.
REQ-028 rst mid-RUN aborts immediately; no done pulse; the next start performs a full call.

Configuration
REQ-029 When SPOC_PERM_ABORT_EN is defined, the block has an input port abort (1 bit); abort=1 in DOM or RUN -> IDLE on the next edge, with no done pulse and counters cleared.
REQ-030 abort has priority over the RUN->DONE transition in the same cycle.
REQ-031 When SPOC_PERM_ABORT_EN is undefined, the abort port does not exist and every call runs to DONE.

Structure
REQ-032 The shared package spoc_pkg holds the state enum, the default NUM_STEPS/ROUNDS_PER_STEP, and the LFSR seed constant RC_SEED=6'h3F.
REQ-033 The LFSR is the single sub-module, perm_rc_lfsr, with ports clk, rst, init, adv and rc.

Verification
REQ-034 Scenario: rst, then start=1 for one cycle with ctrl_word=2'b10 -> dom_word=2'b10 with en_dom at cycle 1, 108 en_state cycles, done at cycle 110 only.
REQ-035 Scenario: RUN cycles 0..2 -> rc=3F, 3E, 3C; step_last high at RUN cycles 5, 11, ..., 107; step_cnt=17 on the final cycle.
REQ-036 Scenario: start pulsed at RUN cycle 40 -> no effect; a single done at cycle 110.
REQ-037 Scenario: start held high through DONE with ctrl_word=2'b01 -> en_dom in the cycle after done; second done 110 cycles after the first start-to-done reference point, with dom_word=2'b01.
REQ-038 Scenario: rst pulsed at RUN cycle 50 -> all outputs 0 at once; the next start yields the full 110-cycle sequence.
REQ-039 Scenario, with SPOC_PERM_ABORT_EN: abort at RUN cycle 107 (the last) -> IDLE, no done; without the macro, the bench compiles with no abort port.
